// File: rtl/imm_pkg.sv
// Shared types and defaults for the image-masking frame-scan controller.
// Holds frame geometry defaults, the scan FSM state encoding and coordinate/pixel types.
package imm_pkg;

  localparam int IMG_W_DEF  = 320;
  localparam int IMG_H_DEF  = 240;
  localparam int PIX_W_DEF  = 12;
  localparam int ADDR_W_DEF = 17;

  localparam int CI_W = 9;
  localparam int CJ_W = 8;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef logic [CI_W-1:0]      coord_i_t;
  typedef logic [CJ_W-1:0]      coord_j_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_FETCH,
    ST_APPLY,
    ST_WRITE,
    ST_DONE
  } imm_state_e;

  // True on the bottom-right pixel of a w x h frame.
  function automatic logic is_last(input coord_i_t i, input coord_j_t j,
                                   input int w, input int h);
    return (i == coord_i_t'(w - 1)) && (j == coord_j_t'(h - 1));
  endfunction

endpackage

// File: rtl/imm_scan_ctrl_if.sv
// Bundle of host, source-RAM, masking-datapath and VGA-write signals of the scan controller.
// The master modport is the controller side; slave is the surrounding system.
interface imm_scan_ctrl_if import imm_pkg::*; #(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              start;
  coord_i_t          i_offset_in;
  coord_j_t          j_offset_in;
  logic              busy;
  logic              done;

  logic              src_rd_en;
  logic [ADDR_W-1:0] src_addr;
  logic [PIX_W-1:0]  src_rd_data;

  logic [PIX_W-1:0]  dp_pixel;
  coord_i_t          dp_i;
  coord_j_t          dp_j;
  coord_i_t          dp_i_offset;
  coord_j_t          dp_j_offset;
  logic              dp_valid;
  logic [PIX_W-1:0]  dp_result;

  // VGA write: a beat transfers on a rising edge where vga_wr_valid && vga_wr_ready;
  // once valid rises, valid/addr/data hold unchanged until that transfer.
  logic              vga_wr_valid;
  logic [ADDR_W-1:0] vga_wr_addr;
  logic [PIX_W-1:0]  vga_wr_data;
  logic              vga_wr_ready;

  modport master (
    input  start, i_offset_in, j_offset_in, src_rd_data, dp_result, vga_wr_ready,
    output busy, done, src_rd_en, src_addr, dp_pixel, dp_i, dp_j,
           dp_i_offset, dp_j_offset, dp_valid, vga_wr_valid, vga_wr_addr, vga_wr_data
  );

  modport slave (
    output start, i_offset_in, j_offset_in, src_rd_data, dp_result, vga_wr_ready,
    input  busy, done, src_rd_en, src_addr, dp_pixel, dp_i, dp_j,
           dp_i_offset, dp_j_offset, dp_valid, vga_wr_valid, vga_wr_addr, vga_wr_data
  );

endinterface

// File: rtl/imm_scan_cnt.sv
// Row-major pixel walker: i/j coordinates plus a running linear address (no multiplier).
// clr_i has priority over adv_i; last_o flags the final pixel of the frame.
module imm_scan_cnt import imm_pkg::*; #(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              adv_i,
  output coord_i_t          i_o,
  output coord_j_t          j_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam coord_i_t I_LAST = coord_i_t'(IMG_W - 1);

  coord_i_t          i_q, i_d;
  coord_j_t          j_q, j_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    addr_d = addr_q;
    if (clr_i) begin
      i_d    = '0;
      j_d    = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = addr_q + ADDR_W'(1);
      if (i_q == I_LAST) begin
        i_d = '0;
        j_d = j_q + coord_j_t'(1);
      end else begin
        i_d = i_q + coord_i_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= '0;
      j_q    <= '0;
      addr_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      addr_q <= addr_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign addr_o = addr_q;
  assign last_o = is_last(i_q, j_q, IMG_W, IMG_H);

endmodule

// File: rtl/imm_scan_ctrl.sv
// Frame-scan controller: read source pixel, feed masking datapath, write result to VGA buffer.
// Build option IMM_CTRL_AUTO_RESTART_EN: after DONE rescan continuously, re-latching offsets.
module imm_scan_ctrl import imm_pkg::*; #(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  imm_scan_ctrl_if.master bus,
  output imm_state_e      state_o
);

  imm_state_e        state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  coord_i_t          ioff_q, ioff_d;
  coord_j_t          joff_q, joff_d;

  logic              cnt_clr;
  logic              cnt_adv;
  logic              cnt_last;
  coord_i_t          cnt_i;
  coord_j_t          cnt_j;
  logic [ADDR_W-1:0] cnt_addr;

  imm_scan_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .i_o    (cnt_i),
    .j_o    (cnt_j),
    .addr_o (cnt_addr),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      ioff_q     <= '0;
      joff_q     <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      ioff_q     <= ioff_d;
      joff_q     <= joff_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = wr_valid_q;
    ioff_d     = ioff_q;
    joff_d     = joff_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ioff_d  = bus.i_offset_in;
          joff_d  = bus.j_offset_in;
          cnt_clr = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_FETCH;
      ST_FETCH: begin
        pix_d   = bus.src_rd_data;
        state_d = ST_APPLY;
      end
      ST_APPLY: state_d = ST_WRITE;
      ST_WRITE: begin
        // First WRITE cycle only latches the datapath result; the request opens next cycle.
        if (!wr_valid_q) begin
          wr_data_d  = bus.dp_result;
          wr_valid_d = 1'b1;
        end else if (bus.vga_wr_ready) begin
          wr_valid_d = 1'b0;
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_adv = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
`ifdef IMM_CTRL_AUTO_RESTART_EN
        ioff_d  = bus.i_offset_in;
        joff_d  = bus.j_offset_in;
        cnt_clr = 1'b1;
        state_d = ST_READ;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.src_rd_en    = (state_q == ST_READ);
  assign bus.src_addr     = cnt_addr;
  assign bus.dp_pixel     = pix_q;
  assign bus.dp_i         = cnt_i;
  assign bus.dp_j         = cnt_j;
  assign bus.dp_i_offset  = ioff_q;
  assign bus.dp_j_offset  = joff_q;
  assign bus.dp_valid     = (state_q == ST_APPLY);
  assign bus.vga_wr_valid = wr_valid_q;
  assign bus.vga_wr_addr  = cnt_addr;
  assign bus.vga_wr_data  = wr_data_q;

  assign state_o = state_q;

endmodule

// File: tb/tb_imm_scan_ctrl.sv
// Directed bench for imm_scan_ctrl on a 4x2 frame with RAM and datapath models and a write scoreboard.
// Cycle numbering: the cycle in which start is high is cycle 1.
module tb_imm_scan_ctrl;
  import imm_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int PW   = 12;
  localparam int AW   = 17;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  imm_state_e state_o;

  imm_scan_ctrl_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  imm_scan_ctrl #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (PW),
    .ADDR_W (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int stall_addr = -1;
  bit stall_done = 1'b0;
  logic [AW+PW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Masking rule of the datapath model: checkerboard shifted by the offsets.
  function automatic bit in_mask(input int i, input int j, input int io, input int jo);
    return ((i + io + j + jo) % 2) == 0;
  endfunction

  task automatic push_frame(input int io, input int jo);
    for (int a = 0; a < NPIX; a++) begin
      logic [PW-1:0] px;
      px = PW'(a);
      if (in_mask(a % W, a / W, io, jo)) px = px ^ {PW{1'b1}};
      exp_q.push_back({AW'(a), px});
    end
  endtask

  task automatic check_zero(input string p);
    chk({p, "_busy"},     32'(bus.busy), 0);
    chk({p, "_done"},     32'(bus.done), 0);
    chk({p, "_rd_en"},    32'(bus.src_rd_en), 0);
    chk({p, "_dp_valid"}, 32'(bus.dp_valid), 0);
    chk({p, "_wr_valid"}, 32'(bus.vga_wr_valid), 0);
    chk({p, "_src_addr"}, 32'(bus.src_addr), 0);
    chk({p, "_wr_addr"},  32'(bus.vga_wr_addr), 0);
    chk({p, "_wr_data"},  32'(bus.vga_wr_data), 0);
    chk({p, "_dp_pixel"}, 32'(bus.dp_pixel), 0);
    chk({p, "_dp_i"},     32'(bus.dp_i), 0);
    chk({p, "_dp_j"},     32'(bus.dp_j), 0);
    chk({p, "_i_off"},    32'(bus.dp_i_offset), 0);
    chk({p, "_j_off"},    32'(bus.dp_j_offset), 0);
    chk({p, "_state"},    32'(state_o), 32'(ST_IDLE));
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the start cycle.
  task automatic pulse_start(input int io, input int jo);
    bus.start       = 1'b1;
    bus.i_offset_in = 9'(io);
    bus.j_offset_in = 8'(jo);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input int io, input int jo, input int exp_cyc, input int glitch_cyc);
    int cyc;
    int w0;
    bit got;
    push_frame(io, jo);
    w0 = wr_cnt;
    pulse_start(io, jo);
    cyc = 2;
    got = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    while (cyc < exp_cyc + 20 && !got) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (glitch_cyc > 0 && cyc == glitch_cyc) begin
          bus.start       = 1'b1;
          bus.i_offset_in = 9'(io + 3);
          bus.j_offset_in = 8'(jo + 5);
        end else begin
          bus.start = 1'b0;
        end
        if (glitch_cyc > 0 && cyc == glitch_cyc + 2) begin
          chk("ioff_kept", 32'(bus.dp_i_offset), 32'(io));
          chk("joff_kept", 32'(bus.dp_j_offset), 32'(jo));
          chk("busy_kept", 32'(bus.busy), 1);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(got), 1);
    chk("done_cycle", 32'(cyc), 32'(exp_cyc));
    chk("frame_writes", 32'(wr_cnt - w0), NPIX);
    chk("queue_empty", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(bus.done), 0);
    chk("busy_fall", 32'(bus.busy), 0);
  endtask

  task automatic abort_frame(input int io, input int jo);
    int cyc;
    int d0;
    bit got;
    push_frame(io, jo);
    d0 = done_cnt;
    pulse_start(io, jo);
    cyc = 0;
    got = 1'b0;
    while (cyc < 100 && !got) begin
      if (bus.vga_wr_valid && bus.vga_wr_addr == AW'(3)) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("reach_pix3_write", 32'(got), 1);
    chk("abort_state", 32'(state_o), 32'(ST_WRITE));
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_on_abort", 32'(done_cnt - d0), 0);
    chk("idle_in_rst", 32'(state_o), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Source RAM (data = address) and masking datapath: each answers exactly one cycle later.
  initial begin : env_model
    logic          rd;
    logic          dv;
    logic [AW-1:0] a;
    logic [PW-1:0] res;
    bus.src_rd_data = '0;
    bus.dp_result   = '0;
    forever begin
      @(negedge clk);
      rd  = bus.src_rd_en;
      a   = bus.src_addr;
      dv  = bus.dp_valid;
      res = bus.dp_pixel;
      if (in_mask(int'(bus.dp_i), int'(bus.dp_j), int'(bus.dp_i_offset), int'(bus.dp_j_offset)))
        res = res ^ {PW{1'b1}};
      @(posedge clk); #1;
      bus.src_rd_data = rd ? PW'(a) : PW'(12'hDEA);
      bus.dp_result   = dv ? res : PW'(12'hBAD);
    end
  end

  initial begin : ready_drv
    int stall_cnt;
    stall_cnt = 0;
    bus.vga_wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        stall_cnt--;
        bus.vga_wr_ready = (stall_cnt == 0);
      end else if (bus.vga_wr_valid && int'(bus.vga_wr_addr) == stall_addr && !stall_done) begin
        bus.vga_wr_ready = 1'b0;
        stall_cnt  = 3;
        stall_done = 1'b1;
      end else begin
        bus.vga_wr_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic [AW+PW-1:0] e;
    bit               hold_pend;
    logic [AW-1:0]    hold_addr;
    logic [PW-1:0]    hold_data;
    hold_pend = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pend) begin
          chk("hold_valid", 32'(bus.vga_wr_valid), 1);
          chk("hold_addr", 32'(bus.vga_wr_addr), 32'(hold_addr));
          chk("hold_data", 32'(bus.vga_wr_data), 32'(hold_data));
        end
        hold_pend = bus.vga_wr_valid && !bus.vga_wr_ready;
        hold_addr = bus.vga_wr_addr;
        hold_data = bus.vga_wr_data;
        if (bus.vga_wr_valid && bus.vga_wr_ready) begin
          wr_cnt++;
          chk("write_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.vga_wr_addr), 32'(e[AW+PW-1:PW]));
            chk("wr_data", 32'(bus.vga_wr_data), 32'(e[PW-1:0]));
          end
        end
        if (bus.done) done_cnt++;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.start       = 1'b0;
    bus.i_offset_in = '0;
    bus.j_offset_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef IMM_CTRL_AUTO_RESTART_EN
    begin : auto_seq
      int cyc;
      int d1;
      int d2;
      push_frame(10, 20);
      push_frame(2, 1);
      pulse_start(10, 20);
      bus.i_offset_in = 9'd2;
      bus.j_offset_in = 8'd1;
      cyc = 2;
      d1 = 0;
      d2 = 0;
      while (cyc < 200 && d2 == 0) begin
        if (bus.done) begin
          if (d1 == 0) d1 = cyc;
          else d2 = cyc;
        end
        if (d1 != 0 && cyc == d1 + 1) chk("busy_held", 32'(bus.busy), 1);
        @(posedge clk); #1;
        cyc++;
      end
      chk("first_done", 32'(d1), 42);
      chk("second_done", 32'(d2), 83);
      chk("auto_writes", 32'(wr_cnt), 2 * NPIX);
      chk("auto_queue", 32'(exp_q.size()), 0);
      rst_n = 1'b0;
      #1;
      check_zero("stop");
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
`else
    // Plain frame: 5 cycles per pixel plus start and done cycles.
    run_frame(10, 20, 42, 0);
    // Pixel 5 stalled three cycles, with a stray start pulse mid-frame.
    stall_addr = 5;
    stall_done = 1'b0;
    run_frame(1, 0, 45, 12);
    stall_addr = -1;
    chk("stall_happened", 32'(stall_done), 1);
    // Reset inside pixel 3's WRITE, then a fresh frame from address 0.
    abort_frame(5, 7);
    run_frame(0, 1, 42, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
